multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have `reset`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have `instr_type`, input, 2 bits: instruction[27:26]. 00 = data-processing, 01 = load/store, 10 = branch, 11 = illegal.
REQ-004 The block SHALL have `cond`, input, 4 bits: instruction[31:28], the ARM condition code.
REQ-005 The block SHALL have `i_bit`, input, 1 bit: instruction[25], immediate select.
REQ-006 The block SHALL have `s_bit`, input, 1 bit: instruction[20]; set-flags for data-processing, L (load) for load/store.
REQ-007 The block SHALL have `rd`, input, 4 bits: destination register.
REQ-008 The block SHALL have `alu_flags`, input, 4 bits: NZCV from the ALU in the current cycle.
REQ-009 The block SHALL have `mem_ready`, input, 1 bit: memory completes the current access this cycle.
REQ-010 The block SHALL have `mem_req`, output, 1 bit: memory access request.
REQ-011 The block SHALL have `mem_we`, output, 1 bit: memory write enable.
REQ-012 The block SHALL have `adr_src`, output, 1 bit: memory address select, 0 = PC, 1 = ALU result register.
REQ-013 The block SHALL have `ir_write`, output, 1 bit: instruction register load.
REQ-014 The block SHALL have `pc_write`, output, 1 bit: PC load.
REQ-015 The block SHALL have `alu_src_a`, output, 1 bit: 0 = register A, 1 = PC.
REQ-016 The block SHALL have `alu_src_b`, output, 2 bits: 00 = register B, 01 = extended immediate, 10 = constant 4.
REQ-017 The block SHALL have `result_src`, output, 2 bits: 00 = ALU result register, 01 = memory data, 10 = ALU direct.
REQ-018 The block SHALL have `reg_write`, output, 1 bit: register-file write.
REQ-019 The block SHALL have `flags`, output, 4 bits: the architectural NZCV register.
REQ-020 The block SHALL have `illegal_instr`, output, 1 bit: one-cycle pulse when an illegal instruction is decoded.

Function
REQ-021 The FSM states SHALL be FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH.
REQ-022 Every output not asserted by the current state SHALL be 0.
REQ-023 FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=1, `alu_src_b`=10, `result_src`=10.
- `ir_write` and `pc_write` = `mem_ready`.
- Stay in FETCH until `mem_ready`, then go to DECODE.
REQ-024 DECODE: one cycle, no outputs asserted. Next state:
- condition fails -> FETCH
- `instr_type` 00 -> EXECUTE
- 01 -> MEM_ADDR
- 10 -> BRANCH
- 11 -> FETCH, with `illegal_instr`=1 for that cycle.
REQ-025 EXECUTE: `alu_src_a`=0, `alu_src_b` = `i_bit` ? 01 : 00; go to ALU_WB.
REQ-026 ALU_WB:
- `reg_write`=1, `result_src`=00.
- `pc_write`=1 when `rd`==15.
- When `s_bit`=1, `flags` loads `alu_flags` at the end of this cycle.
- Go to FETCH.
REQ-027 MEM_ADDR: `alu_src_a`=0, `alu_src_b`=01; go to MEM_READ if `s_bit`=1, else MEM_WRITE.
REQ-028 MEM_READ: `mem_req`=1, `adr_src`=1; hold until `mem_ready`, then go to MEM_WB.
REQ-029 MEM_WB: `reg_write`=1, `result_src`=01; `pc_write`=1 when `rd`==15; go to FETCH.
REQ-030 MEM_WRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1; hold until `mem_ready`, then go to FETCH.
REQ-031 BRANCH: `alu_src_a`=1, `alu_src_b`=01, `result_src`=10, `pc_write`=1; go to FETCH.
REQ-032 With zero-wait memory, latencies in cycles SHALL be:
- data-processing 4, load 5, store 4, branch 3
- condition-failed or illegal 2
Each wait cycle with `mem_ready`=0 adds exactly one cycle.
REQ-033 `mem_req` and `mem_we` SHALL stay stable while waiting; the block never withdraws a request before `mem_ready`.
REQ-034 `mem_ready` outside FETCH, MEM_READ and MEM_WRITE SHALL be ignored.
REQ-035 The condition SHALL be evaluated in DECODE against the current `flags`, using ARM semantics for codes 0000–1110; code 1111 is treated as never.

Reset
REQ-036 While `reset`=1 at a clock edge, the state SHALL become FETCH and `flags` SHALL become 0000.
REQ-037 During the reset cycle all outputs SHALL be 0, so no memory request or register write is issued.
REQ-038 Reset mid-instruction (including during a memory wait) SHALL abandon the instruction, with no partial write and no flag update.

Configuration
REQ-039 With `COND_EXEC_EN` defined:
- conditional execution per REQ-035 applies;
- the `flags` register is implemented.
REQ-040 Without `COND_EXEC_EN`:
- every instruction executes as if `cond`=1110;
- `flags` is tied to 0000 and `s_bit` has no flag effect.

Structure
REQ-041 Package `multicycle_pkg` SHALL hold:
- the state enum;
- the `instr_type`, `alu_src_b` and `result_src` encodings;
- the condition-code constants.
REQ-042 Sub-module `cond_unit` (combinational, `cond` + `flags` -> pass) SHALL be instantiated only under `COND_EXEC_EN`.

Verification
REQ-043 Reset, then ADD with S=1, `cond`=1110, `mem_ready`=1, `alu_flags`=0100 -> states FETCH, DECODE, EXECUTE, ALU_WB; `reg_write` in cycle 4; `flags`=0100 afterwards.
REQ-044 LDR (type 01, L=1, `rd`=3) with `mem_ready` low for 2 cycles in MEM_READ -> `mem_req`/`adr_src`=1 held for 3 cycles; MEM_WB has `reg_write`=1, `result_src`=01; 7 cycles total.
REQ-045 `flags`=0000, branch with `cond`=0000 (EQ) -> DECODE returns to FETCH with no `pc_write` beyond fetch; with `flags`=0100 -> BRANCH asserts `pc_write`.
REQ-046 `instr_type`=11 -> `illegal_instr` pulses one cycle in DECODE, next state FETCH, no writes.
REQ-047 STR with `reset` asserted during a MEM_WRITE wait -> next cycle FETCH, `mem_we`=0, `flags` cleared.
REQ-048 Data-processing with `rd`=15 -> `pc_write` and `reg_write` both 1 in ALU_WB.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction classes,
// datapath mux selects and ARM condition codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    EXECUTE    = 4'd2,
    ALU_WB     = 4'd3,
    MEM_ADDR   = 4'd4,
    MEM_READ   = 4'd5,
    MEM_WB     = 4'd6,
    MEM_WRITE  = 4'd7,
    BRANCH     = 4'd8
  } state_e;

  // instruction[27:26]
  localparam logic [1:0] ITYPE_DP  = 2'b00;
  localparam logic [1:0] ITYPE_MEM = 2'b01;
  localparam logic [1:0] ITYPE_BR  = 2'b10;
  localparam logic [1:0] ITYPE_ILL = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the NZCV nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/multicycle_controller_if.sv
// Decode-field / control bundle between the multicycle controller (slave) and the
// datapath driving it (master).
interface multicycle_controller_if;

  logic [1:0] instr_type;
  logic [3:0] cond;
  logic       i_bit;
  logic       s_bit;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       reg_write;
  logic [3:0] flags;
  logic       illegal_instr;

  modport slave (
    input  instr_type, cond, i_bit, s_bit, rd, alu_flags, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a,
           alu_src_b, result_src, reg_write, flags, illegal_instr
  );

  modport master (
    output instr_type, cond, i_bit, s_bit, rd, alu_flags, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a,
           alu_src_b, result_src, reg_write, flags, illegal_instr
  );

endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// Combinational ARM condition check: cond field against current NZCV, 1111 never passes.
module cond_unit
  import multicycle_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM. Define COND_EXEC_EN to enable conditional
// execution and the NZCV flags register; otherwise every instruction runs as AL.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.slave  bus
);

  state_e     state_q;
  logic [3:0] flags_q;
  logic       cond_pass;

`ifdef COND_EXEC_EN
  logic [3:0] flags_d;

  cond_unit u_cond (
    .cond  (bus.cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    flags_d = flags_q;
    if (state_q == ALU_WB && bus.s_bit) flags_d = bus.alu_flags;
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end
`else
  logic unused_cond_fields;

  assign cond_pass          = 1'b1;
  assign flags_q            = 4'b0000;
  assign unused_cond_fields = ^{bus.cond, bus.alu_flags};
`endif

  assign bus.flags = flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:     if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          if (!cond_pass) begin
            state_q <= FETCH;
          end else begin
            case (bus.instr_type)
              ITYPE_DP:  state_q <= EXECUTE;
              ITYPE_MEM: state_q <= MEM_ADDR;
              ITYPE_BR:  state_q <= BRANCH;
              default:   state_q <= FETCH;
            endcase
          end
        end
        EXECUTE:   state_q <= ALU_WB;
        ALU_WB:    state_q <= FETCH;
        MEM_ADDR:  state_q <= bus.s_bit ? MEM_READ : MEM_WRITE;
        MEM_READ:  if (bus.mem_ready) state_q <= MEM_WB;
        MEM_WB:    state_q <= FETCH;
        MEM_WRITE: if (bus.mem_ready) state_q <= FETCH;
        BRANCH:    state_q <= FETCH;
        default:   state_q <= FETCH;
      endcase
    end
  end

  // Outputs decode the registered state; reset forces them quiet in the reset cycle itself.
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.adr_src       = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.result_src    = RES_ALUOUT;
    bus.reg_write     = 1'b0;
    bus.illegal_instr = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALU;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        DECODE: begin
          bus.illegal_instr = cond_pass && (bus.instr_type == ITYPE_ILL);
        end
        EXECUTE: begin
          bus.alu_src_b = bus.i_bit ? SRCB_IMM : SRCB_REG;
        end
        ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = RES_ALUOUT;
          bus.pc_write   = (bus.rd == 4'd15);
        end
        MEM_ADDR: begin
          bus.alu_src_b = SRCB_IMM;
        end
        MEM_READ: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = RES_MEM;
          bus.pc_write   = (bus.rd == 4'd15);
        end
        MEM_WRITE: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.adr_src = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = SRCB_IMM;
          bus.result_src = RES_ALU;
          bus.pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
